mem_stage: RTL and testbench

Memory-access pipeline stage that sits directly upstream of the write-back stage. It takes the EX/MEM result and performs loads and stores through a req/ack data-memory port. Load data is aligned and sign- or zero-extended, and store data is replicated across byte lanes. It registers aluResult1, Data_input1, writeRegister1, MemtoReg1 and do_writeback1 for write-back, and raises a stall toward upstream while a memory transaction is outstanding.

---
 rtl/mem_stage.sv | 213 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX/MEM and write-back.
// Performs loads/stores over a req/ack data-memory port, aligns and extends
// load data, replicates store data across lanes and stalls upstream while
// a transaction is outstanding. Unanswered requests are aborted after TIMEOUT.
module mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        valid_IN,
    input  logic [31:0] aluResult_IN,
    input  logic [31:0] storeData_IN,
    input  logic [4:0]  writeRegister_IN,
    input  logic        do_writeback_IN,
    input  logic        MemRead_IN,
    input  logic        MemWrite_IN,
    input  logic        MemtoReg_IN,
    input  logic [1:0]  memSize_IN,
    input  logic        memSigned_IN,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_OUT,
    output logic [31:0] aluResult1,
    output logic [31:0] Data_input1,
    output logic [4:0]  writeRegister1,
    output logic        MemtoReg1,
    output logic        do_writeback1,
    output logic        misaligned_OUT,
    output logic        bus_error_OUT
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [31:0] addr_q, wdata_q;
    logic        we_q, sgn_q, mtr_q, wb_q;
    logic [3:0]  be_q;
    logic [1:0]  size_q;
    logic [4:0]  wr_q;

    logic [31:0] alu_d, data_d;
    logic [4:0]  wr_d;
    logic        mtr_d, wb_d, mis_d, berr_d;
    logic        latch_en, stall_c, mem_op, misaligned;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    lane_be = 4'b0001 << off;
            2'd1:    lane_be = off[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'd0:    lane_wdata = {4{d[7:0]}};
            2'd1:    lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    // Size 3 is handled as a word, so size[1] covers both word encodings.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        is_misaligned = ((size == 2'd1) && off[0]) || (size[1] && (off != 2'd0));
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] off,
                                                 input logic sgn, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'd0:    load_extract = {{24{sgn & b[7]}}, b};
            2'd1:    load_extract = {{16{sgn & h[15]}}, h};
            default: load_extract = rdata;
        endcase
    endfunction

    assign mem_op     = MemRead_IN | MemWrite_IN;
    assign misaligned = is_misaligned(memSize_IN, aluResult_IN[1:0]);

    // Next state, timeout counting and write-back values; ack beats timeout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        stall_c  = 1'b0;
        alu_d    = 32'd0;
        data_d   = 32'd0;
        wr_d     = 5'd0;
        mtr_d    = 1'b0;
        wb_d     = 1'b0;
        mis_d    = 1'b0;
        berr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_IN) begin
                    if (!mem_op) begin
                        alu_d = aluResult_IN;
                        wr_d  = writeRegister_IN;
                        mtr_d = MemtoReg_IN;
                        wb_d  = do_writeback_IN;
                    end else if (misaligned) begin
                        mis_d = 1'b1;
                    end else begin
                        latch_en = 1'b1;
                        stall_c  = 1'b1;
                        cnt_d    = 8'd0;
                        state_d  = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    state_d = IDLE;
                    alu_d   = addr_q;
                    data_d  = we_q ? 32'd0 : load_extract(size_q, addr_q[1:0], sgn_q, dmem_rdata);
                    wr_d    = wr_q;
                    mtr_d   = mtr_q;
                    wb_d    = wb_q & ~we_q;
                end else if (cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    stall_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_OUT  = RESET & stall_c;
    assign dmem_req   = (state_q == ACCESS);
    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_we    = we_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

    // FSM state and timeout counter.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the accepted memory op so the bus stays stable until ack.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            size_q  <= 2'd0;
            sgn_q   <= 1'b0;
            wr_q    <= 5'd0;
            mtr_q   <= 1'b0;
            wb_q    <= 1'b0;
        end else if (latch_en) begin
            addr_q  <= aluResult_IN;
            wdata_q <= lane_wdata(memSize_IN, storeData_IN);
            we_q    <= MemWrite_IN;
            be_q    <= lane_be(memSize_IN, aluResult_IN[1:0]);
            size_q  <= memSize_IN;
            sgn_q   <= memSigned_IN;
            wr_q    <= writeRegister_IN;
            mtr_q   <= MemtoReg_IN;
            wb_q    <= do_writeback_IN;
        end
    end

    // Write-back register and one-cycle status pulses.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            aluResult1     <= 32'd0;
            Data_input1    <= 32'd0;
            writeRegister1 <= 5'd0;
            MemtoReg1      <= 1'b0;
            do_writeback1  <= 1'b0;
            misaligned_OUT <= 1'b0;
            bus_error_OUT  <= 1'b0;
        end else begin
            aluResult1     <= alu_d;
            Data_input1    <= data_d;
            writeRegister1 <= wr_d;
            MemtoReg1      <= mtr_d;
            do_writeback1  <= wb_d;
            misaligned_OUT <= mis_d;
            bus_error_OUT  <= berr_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed transactions against a transaction-level
// model, compared on every falling edge, plus hand-computed expectations.
module tb_mem_stage;

    localparam int TO = 4;

    logic        CLK, RESET;
    logic        valid_IN, do_writeback_IN, MemRead_IN, MemWrite_IN, MemtoReg_IN, memSigned_IN;
    logic [31:0] aluResult_IN, storeData_IN;
    logic [4:0]  writeRegister_IN;
    logic [1:0]  memSize_IN;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stall_OUT, MemtoReg1, do_writeback1, misaligned_OUT, bus_error_OUT;
    logic [31:0] aluResult1, Data_input1;
    logic [4:0]  writeRegister1;

    int checks = 0;
    int passed = 0;

    mem_stage #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET(RESET), .valid_IN(valid_IN), .aluResult_IN(aluResult_IN),
        .storeData_IN(storeData_IN), .writeRegister_IN(writeRegister_IN),
        .do_writeback_IN(do_writeback_IN), .MemRead_IN(MemRead_IN), .MemWrite_IN(MemWrite_IN),
        .MemtoReg_IN(MemtoReg_IN), .memSize_IN(memSize_IN), .memSigned_IN(memSigned_IN),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_OUT(stall_OUT),
        .aluResult1(aluResult1), .Data_input1(Data_input1), .writeRegister1(writeRegister1),
        .MemtoReg1(MemtoReg1), .do_writeback1(do_writeback1), .misaligned_OUT(misaligned_OUT),
        .bus_error_OUT(bus_error_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int m_bytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_misaligned(input logic [1:0] size, input logic [31:0] addr);
        return (addr % m_bytes(size)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
        int nb;
        nb = m_bytes(size);
        return 4'(((1 << nb) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] d);
        int nb;
        nb = m_bytes(size);
        if (nb == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (nb == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic [31:0] addr,
                                           input logic sgn, input logic [31:0] rd);
        int nb;
        logic [31:0] mask, v;
        nb   = m_bytes(size);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v    = (rd >> (8 * (addr % 4))) & mask;
        if (sgn && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    bit          m_busy;
    int          m_wait;
    logic [31:0] p_addr, p_d;
    logic        p_we, p_sgn, p_mtr, p_wb;
    logic [1:0]  p_size;
    logic [4:0]  p_wr;
    logic [31:0] e_alu, e_data;
    logic [4:0]  e_wr;
    logic        e_mtr, e_wb, e_mis, e_berr;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_busy <= 0; m_wait <= 0;
            e_alu <= 0; e_data <= 0; e_wr <= 0; e_mtr <= 0; e_wb <= 0; e_mis <= 0; e_berr <= 0;
        end else begin
            e_alu <= 0; e_data <= 0; e_wr <= 0; e_mtr <= 0; e_wb <= 0; e_mis <= 0; e_berr <= 0;
            if (!m_busy) begin
                if (valid_IN) begin
                    if (!(MemRead_IN || MemWrite_IN)) begin
                        e_alu <= aluResult_IN; e_wr <= writeRegister_IN;
                        e_mtr <= MemtoReg_IN;  e_wb <= do_writeback_IN;
                    end else if (m_misaligned(memSize_IN, aluResult_IN)) begin
                        e_mis <= 1;
                    end else begin
                        m_busy <= 1; m_wait <= 0;
                        p_addr <= aluResult_IN; p_d <= storeData_IN; p_we <= MemWrite_IN;
                        p_size <= memSize_IN; p_sgn <= memSigned_IN; p_wr <= writeRegister_IN;
                        p_mtr <= MemtoReg_IN; p_wb <= do_writeback_IN;
                    end
                end
            end else if (dmem_ack) begin
                m_busy <= 0;
                e_alu  <= p_addr;
                e_data <= p_we ? 32'd0 : m_load(p_size, p_addr, p_sgn, dmem_rdata);
                e_wr   <= p_wr; e_mtr <= p_mtr; e_wb <= p_wb && !p_we;
            end else if (m_wait + 1 >= TO) begin
                m_busy <= 0; e_berr <= 1;
            end else begin
                m_wait <= m_wait + 1;
            end
        end
    end

    // Every falling edge: DUT outputs against the model.
    always @(negedge CLK) begin
        logic exp_stall;
        if (!RESET) exp_stall = 0;
        else if (m_busy) exp_stall = !dmem_ack && (m_wait + 1 < TO);
        else exp_stall = valid_IN && (MemRead_IN || MemWrite_IN) && !m_misaligned(memSize_IN, aluResult_IN);
        check("model dmem_req", dmem_req, m_busy);
        check("model stall_OUT", stall_OUT, exp_stall);
        if (m_busy) begin
            check("model dmem_addr", dmem_addr, p_addr & ~32'd3);
            check("model dmem_we", dmem_we, p_we);
            check("model dmem_be", dmem_be, m_be(p_size, p_addr));
            if (p_we) check("model dmem_wdata", dmem_wdata, m_wdata(p_size, p_d));
        end
        check("model aluResult1", aluResult1, e_alu);
        check("model Data_input1", Data_input1, e_data);
        check("model writeRegister1", writeRegister1, e_wr);
        check("model MemtoReg1", MemtoReg1, e_mtr);
        check("model do_writeback1", do_writeback1, e_wb);
        check("model misaligned_OUT", misaligned_OUT, e_mis);
        check("model bus_error_OUT", bus_error_OUT, e_berr);
    end

    // ---------------- stimulus ----------------
    int          n_stall, n_req, n_berr, n_mis, n_wb;
    logic        cap_we, cap_wb;
    logic [31:0] cap_wdata, cap_alu, cap_data;
    logic [3:0]  cap_be;
    logic [4:0]  cap_wr;

    task automatic set_op(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] d,
                          input logic [4:0] r, input logic wb, input logic mtr);
        valid_IN = v; MemRead_IN = rd; MemWrite_IN = wr; memSize_IN = sz; memSigned_IN = sg;
        aluResult_IN = a; storeData_IN = d; writeRegister_IN = r;
        do_writeback_IN = wb; MemtoReg_IN = mtr;
    endtask

    task automatic set_idle();
        set_op(0, 0, 0, 2'd0, 0, 32'd0, 32'd0, 5'd0, 0, 0);
    endtask

    // Cycle c=0 is the issue cycle; ack is driven in cycle ack_at (-1: never).
    // Inputs are held through hold_until, as upstream would while stalled.
    task automatic run_txn(input int ack_at, input int hold_until, input int ncycles,
                           input logic [31:0] rdata);
        n_stall = 0; n_req = 0; n_berr = 0; n_mis = 0; n_wb = 0;
        for (int c = 0; c < ncycles; c++) begin
            if (c > hold_until) set_idle();
            dmem_ack   = (c == ack_at);
            dmem_rdata = (c == ack_at) ? rdata : 32'h5A5A_5A5A;
            @(negedge CLK);
            if (stall_OUT) n_stall++;
            if (dmem_req) n_req++;
            if (bus_error_OUT) n_berr++;
            if (misaligned_OUT) n_mis++;
            if (do_writeback1) n_wb++;
            if (c == 1) begin cap_we = dmem_we; cap_wdata = dmem_wdata; cap_be = dmem_be; end
            if (c == ncycles - 1) begin
                cap_alu = aluResult1; cap_data = Data_input1; cap_wb = do_writeback1; cap_wr = writeRegister1;
            end
            @(posedge CLK); #1;
        end
        dmem_ack = 0;
        set_idle();
    endtask

    initial begin
        RESET = 0; dmem_ack = 0; dmem_rdata = 32'd0;
        set_idle();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset dmem_req", dmem_req, 0);
        check("reset stall_OUT", stall_OUT, 0);
        check("reset aluResult1", aluResult1, 0);
        check("reset do_writeback1", do_writeback1, 0);
        @(posedge CLK); #1;
        RESET = 1;

        // Non-memory ALU op passes straight through.
        set_op(1, 0, 0, 2'd2, 0, 32'h1234, 32'd0, 5'd5, 1, 0);
        run_txn(-1, 0, 2, 32'd0);
        check("alu aluResult1", cap_alu, 32'h1234);
        check("alu writeRegister1", cap_wr, 5);
        check("alu do_writeback1", cap_wb, 1);
        check("alu no req", n_req, 0);

        // Signed byte load at 0x1003, ack 3 cycles after req.
        set_op(1, 1, 0, 2'd0, 1, 32'h1003, 32'd0, 5'd7, 1, 1);
        run_txn(4, 4, 6, 32'h80FF_0000);
        check("lb be", cap_be, 4'b1000);
        check("lb stall cycles", n_stall, 4);
        check("lb Data_input1", cap_data, 32'hFFFF_FF80);
        check("lb do_writeback1", cap_wb, 1);
        check("lb aluResult1", cap_alu, 32'h1003);

        // Half store at 0x2002.
        set_op(1, 0, 1, 2'd1, 0, 32'h2002, 32'hAAAA_BEEF, 5'd4, 1, 0);
        run_txn(2, 2, 4, 32'h1111_2222);
        check("sh we", cap_we, 1);
        check("sh wdata", cap_wdata, 32'hBEEF_BEEF);
        check("sh be", cap_be, 4'b1100);
        check("sh do_writeback1", cap_wb, 0);

        // Byte store with MemRead and MemWrite both high acts as a store.
        set_op(1, 1, 1, 2'd0, 0, 32'h5001, 32'h1234_56A5, 5'd6, 1, 0);
        run_txn(1, 1, 3, 32'h0);
        check("sb we", cap_we, 1);
        check("sb wdata", cap_wdata, 32'hA5A5_A5A5);
        check("sb be", cap_be, 4'b0010);

        // Misaligned word load is dropped.
        set_op(1, 1, 0, 2'd2, 0, 32'h1001, 32'd0, 5'd8, 1, 1);
        run_txn(-1, 0, 3, 32'd0);
        check("mis pulse", n_mis, 1);
        check("mis no req", n_req, 0);
        check("mis no stall", n_stall, 0);
        check("mis no writeback", n_wb, 0);

        // Unsigned half load at 0x4002.
        set_op(1, 1, 0, 2'd1, 0, 32'h4002, 32'd0, 5'd9, 1, 1);
        run_txn(1, 1, 3, 32'h8001_0000);
        check("lhu Data_input1", cap_data, 32'h0000_8001);

        // No ack: timeout after TO request cycles.
        set_op(1, 1, 0, 2'd2, 0, 32'h3000, 32'd0, 5'd10, 1, 1);
        run_txn(-1, TO, TO + 3, 32'd0);
        check("to req cycles", n_req, TO);
        check("to bus_error pulse", n_berr, 1);
        check("to stall cycles", n_stall, TO);
        check("to idle req", dmem_req, 0);

        // Ack in the last allowed cycle completes normally.
        set_op(1, 1, 0, 2'd2, 0, 32'h3004, 32'd0, 5'd11, 1, 1);
        run_txn(TO, TO, TO + 2, 32'hCAFE_F00D);
        check("late ack no error", n_berr, 0);
        check("late ack req cycles", n_req, TO);
        check("late ack Data_input1", cap_data, 32'hCAFE_F00D);
        check("late ack do_writeback1", cap_wb, 1);

        // Reset in the middle of an access.
        set_op(1, 1, 0, 2'd2, 0, 32'h6000, 32'd0, 5'd3, 1, 1);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("rst pre req", dmem_req, 1);
        check("rst pre addr", dmem_addr, 32'h6000);
        #2 RESET = 0;
        #1;
        check("rst req drop", dmem_req, 0);
        check("rst addr", dmem_addr, 0);
        check("rst stall", stall_OUT, 0);
        check("rst bus_error", bus_error_OUT, 0);
        set_idle();
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1;

        set_op(1, 1, 0, 2'd0, 0, 32'h7002, 32'd0, 5'd12, 1, 1);
        run_txn(2, 2, 4, 32'h00AB_0000);
        check("post rst Data_input1", cap_data, 32'h0000_00AB);
        check("post rst wr", cap_wr, 12);
        check("post rst no error", n_berr, 0);

        repeat (2) @(posedge CLK);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
